// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field map, flit type codes, NI transmit FSM encoding
// and helpers that assemble header/payload flits with the parity bit left at zero.
package noc_pkg;

    localparam int FLIT_W = 32;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 12;
    localparam int PLD_W  = 28;
    localparam int PID_W  = 8;
    localparam int TYPE_W = 3;

    localparam logic [TYPE_W-1:0] HEADER = 3'b001;
    localparam logic [TYPE_W-1:0] BODY   = 3'b010;
    localparam logic [TYPE_W-1:0] TAIL   = 3'b100;

    localparam int TYPE_LSB = 29;
    localparam int LEN_LSB  = 17;
    localparam int DST_LSB  = 13;
    localparam int SRC_LSB  = 9;
    localparam int PID_LSB  = 1;
    localparam int PLD_LSB  = 1;
    localparam int PAR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DRAIN
    } ni_tx_state_e;

    function automatic logic [FLIT_W-1:0] header_flit(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] dst,
        input logic [ADDR_W-1:0] src,
        input logic [PID_W-1:0]  id
    );
        logic [FLIT_W-1:0] f;
        f = '0;
        f[TYPE_LSB +: TYPE_W] = HEADER;
        f[LEN_LSB  +: LEN_W]  = len;
        f[DST_LSB  +: ADDR_W] = dst;
        f[SRC_LSB  +: ADDR_W] = src;
        f[PID_LSB  +: PID_W]  = id;
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] payload_flit(
        input logic [TYPE_W-1:0] ftype,
        input logic [PLD_W-1:0]  pld
    );
        logic [FLIT_W-1:0] f;
        f = '0;
        f[TYPE_LSB +: TYPE_W] = ftype;
        f[PLD_LSB  +: PLD_W]  = pld;
        return f;
    endfunction

endpackage

// File: rtl/flit_parity.sv
// Even-parity bit for the upper 31 flit bits; forced to zero when parity is disabled.
// Shared by the transmit side and the receive-side checker.
module flit_parity
    import noc_pkg::*;
(
    input  logic [FLIT_W-2:0] i_data,
    input  logic              i_parity_en,
    output logic              o_parity
);

    assign o_parity = i_parity_en & (^i_data);

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface transmit side: turns a descriptor plus payload words into
// header/body/tail flits for the router Local port under RTS/CTS flow control.
module noc_ni_tx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     cur_addr,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [ADDR_W-1:0]     pkt_dst,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [PID_W-1:0]      pkt_id,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [PLD_W-1:0]      pld_data,
    output logic [DATA_WIDTH-1:0] TX,
    output logic                  RTS,
    input  logic                  DCTS,
    output logic                  busy,
    output logic                  pkt_sent,
    output logic                  len_err
);

    ni_tx_state_e          r_state;
    logic [LEN_W-1:0]      r_remaining;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_rts;
    logic                  r_pkt_sent;
    logic                  r_len_err;
    logic                  r_ready_en;

    logic                  w_slot_free;
    logic                  w_desc_hs;
    logic                  w_desc_ok;
    logic                  w_pld_hs;
    logic                  w_last;
    logic                  w_par;
    logic [FLIT_W-1:0]     w_flit_base;
    logic [FLIT_W-1:0]     w_flit;

    // The output register may take a new flit whenever the current one is absent or leaving.
    assign w_slot_free = !r_rts | DCTS;
    assign pkt_ready   = r_ready_en & (r_state == ST_IDLE) & w_slot_free;
    assign pld_ready   = (r_state == ST_PAYLOAD) & w_slot_free;
    assign w_desc_hs   = pkt_valid & pkt_ready;
    assign w_desc_ok   = (pkt_len >= 12'd2) && (pkt_dst != cur_addr);
    assign w_pld_hs    = pld_valid & pld_ready;
    assign w_last      = (r_remaining == 12'd1);

    always_comb begin
        // NOTE: both branches assign w_flit_base, so this stays purely combinational (no latch).
        if (r_state == ST_IDLE) begin
            w_flit_base = header_flit(pkt_len, pkt_dst, cur_addr, pkt_id);
        end else begin
            w_flit_base = payload_flit(w_last ? TAIL : BODY, pld_data);
        end
    end

    flit_parity u_flit_parity (
        .i_data      (w_flit_base[FLIT_W-1:PAR_LSB+1]),
        .i_parity_en (PARITY_EN),
        .o_parity    (w_par)
    );

    assign w_flit = w_flit_base | (FLIT_W'(w_par) << PAR_LSB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_tx        <= '0;
            r_rts       <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_len_err   <= 1'b0;
            r_ready_en  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            r_ready_en <= 1'b1;
            r_pkt_sent <= 1'b0;
            r_len_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_desc_hs) begin
                        if (w_desc_ok) begin
                            r_tx        <= w_flit;
                            r_rts       <= 1'b1;
                            r_remaining <= pkt_len - 12'd1;
                            r_state     <= ST_PAYLOAD;
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_pld_hs) begin
                        r_tx        <= w_flit;
                        r_rts       <= 1'b1;
                        r_remaining <= r_remaining - 12'd1;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_slot_free) begin
                        r_rts <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The tail is always presented here, so DCTS alone means it was taken.
                    if (DCTS) begin
                        r_rts      <= 1'b0;
                        r_pkt_sent <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign TX       = r_tx;
    assign RTS      = r_rts;
    assign pkt_sent = r_pkt_sent;
    assign len_err  = r_len_err;
    assign busy     = (r_state != ST_IDLE) | r_rts;

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed self-checking bench for noc_ni_tx; a second instance with parity
// disabled shares all inputs so the bit[0] behaviour can be compared side by side.
module tb_noc_ni_tx;

    logic        clk;
    logic        rst;
    logic [3:0]  cur_addr;
    logic        pkt_valid;
    logic [3:0]  pkt_dst;
    logic [11:0] pkt_len;
    logic [7:0]  pkt_id;
    logic        pld_valid;
    logic [27:0] pld_data;
    logic        DCTS;

    logic        pkt_ready, pld_ready, RTS, busy, pkt_sent, len_err;
    logic [31:0] TX;
    logic        pkt_ready_np, pld_ready_np, rts_np, busy_np, pkt_sent_np, len_err_np;
    logic [31:0] tx_np;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap     [0:8191];
    logic [31:0] cap_np  [0:8191];
    int          cap_cyc [0:8191];
    int          cap_n    = 0;
    int          cyc_n    = 0;
    int          n_rts    = 0;
    int          n_sent   = 0;
    int          n_lenerr = 0;
    int          sent_cyc = 0;
    logic [27:0] pw [0:4095];

    noc_ni_tx #(.DATA_WIDTH(32), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .cur_addr(cur_addr),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst),
        .pkt_len(pkt_len), .pkt_id(pkt_id),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .TX(TX), .RTS(RTS), .DCTS(DCTS),
        .busy(busy), .pkt_sent(pkt_sent), .len_err(len_err)
    );

    noc_ni_tx #(.DATA_WIDTH(32), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .rst(rst), .cur_addr(cur_addr),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready_np), .pkt_dst(pkt_dst),
        .pkt_len(pkt_len), .pkt_id(pkt_id),
        .pld_valid(pld_valid), .pld_ready(pld_ready_np), .pld_data(pld_data),
        .TX(tx_np), .RTS(rts_np), .DCTS(DCTS),
        .busy(busy_np), .pkt_sent(pkt_sent_np), .len_err(len_err_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after posedge, so a flit seen valid here transfers at the next posedge.
    always @(negedge clk) begin
        if (RTS && DCTS && cap_n < 8192) begin
            cap[cap_n]     = TX;
            cap_np[cap_n]  = tx_np;
            cap_cyc[cap_n] = cyc_n;
            cap_n++;
        end
        if (RTS) n_rts++;
        if (pkt_sent) begin
            n_sent++;
            sent_cyc = cyc_n;
        end
        if (len_err) n_lenerr++;
        cyc_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present_desc(input logic [3:0] dst, input logic [11:0] len, input logic [7:0] id);
        int waited = 0;
        pkt_dst   = dst;
        pkt_len   = len;
        pkt_id    = id;
        pkt_valid = 1'b1;
        @(negedge clk);
        while (!pkt_ready && waited < 50) begin
            tick();
            @(negedge clk);
            waited++;
        end
        check("desc_accept", {31'd0, pkt_ready}, 32'd1);
        tick();
        pkt_valid = 1'b0;
        pkt_dst   = ~dst;
        pkt_len   = 12'hABC;
        pkt_id    = ~id;
    endtask

    task automatic stream_payload(input int nw, input int starve);
        int idx = 0;
        int cyc = 0;
        logic hs;
        while (idx < nw && cyc < nw * 4 + 50) begin
            pld_valid = (cyc >= starve);
            pld_data  = pw[idx];
            @(negedge clk);
            hs = pld_valid & pld_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        pld_valid = 1'b0;
        check("pld_words", idx, nw);
    endtask

    task automatic wait_sent(input int target);
        int c = 0;
        while (n_sent < target && c < 100) begin
            tick();
            c++;
        end
        check("pkt_sent_count", n_sent, target);
    endtask

    task automatic check_basic_flits(input string tag, input int base);
        check({tag, "_count"}, cap_n - base, 3);
        check({tag, "_hdr"},  cap[base],     32'h200660B5);
        check({tag, "_body"}, cap[base + 1], 32'h40000002);
        check({tag, "_tail"}, cap[base + 2], 32'h80000007);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent0;
        int r0;
        int e0;

        rst = 1'b0; cur_addr = 4'd0; pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
        pkt_id = '0; pld_valid = 1'b0; pld_data = '0; DCTS = 1'b1;

        #12;
        check("rst_tx",       TX, 32'h0);
        check("rst_rts",      {31'd0, RTS}, 32'd0);
        check("rst_pkt_ready",{31'd0, pkt_ready}, 32'd0);
        check("rst_pld_ready",{31'd0, pld_ready}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_pulses",   {30'd0, pkt_sent, len_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("idle_pkt_ready", {31'd0, pkt_ready}, 32'd1);

        // Basic 3-flit packet with DCTS held high.
        pw[0] = 28'h1; pw[1] = 28'h3;
        base = cap_n;
        present_desc(4'd3, 12'd3, 8'h5A);
        check("t1_hdr_latency", TX, 32'h200660B5);
        check("t1_hdr_rts", {31'd0, RTS}, 32'd1);
        stream_payload(2, 0);
        wait_sent(1);
        check_basic_flits("t1", base);
        check("t1_gap0", cap_cyc[base + 1] - cap_cyc[base], 1);
        check("t1_gap1", cap_cyc[base + 2] - cap_cyc[base + 1], 1);
        check("t1_sent_timing", sent_cyc, cap_cyc[base + 2] + 1);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Backpressure: header held for four cycles while DCTS is low.
        DCTS = 1'b0;
        base = cap_n;
        present_desc(4'd3, 12'd3, 8'h5A);
        pld_valid = 1'b1;
        pld_data  = 28'h1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("t2_hold_tx", TX, 32'h200660B5);
            check("t2_hold_rts", {31'd0, RTS}, 32'd1);
            check("t2_pld_ready", {31'd0, pld_ready}, 32'd0);
        end
        DCTS = 1'b1;
        stream_payload(2, 0);
        wait_sent(2);
        check_basic_flits("t2", base);

        // Payload starvation for two cycles after the header.
        base = cap_n;
        present_desc(4'd3, 12'd3, 8'h5A);
        pld_valid = 1'b0;
        tick();
        check("t3_bubble0", {31'd0, RTS}, 32'd0);
        tick();
        check("t3_bubble1", {31'd0, RTS}, 32'd0);
        stream_payload(2, 0);
        wait_sent(3);
        check_basic_flits("t3", base);

        // Illegal descriptors: len=1, len=0, dst equal to own address.
        r0 = n_rts;
        e0 = n_lenerr;
        present_desc(4'd3, 12'd1, 8'h01);
        check("t4_len1_err", {31'd0, len_err}, 32'd1);
        check("t4_len1_rts", {31'd0, RTS}, 32'd0);
        tick();
        check("t4_err_pulse", {31'd0, len_err}, 32'd0);
        present_desc(4'd3, 12'd0, 8'h02);
        check("t4_len0_err", {31'd0, len_err}, 32'd1);
        present_desc(4'd0, 12'd3, 8'h03);
        check("t4_self_err", {31'd0, len_err}, 32'd1);
        tick();
        tick();
        check("t4_no_rts", n_rts - r0, 0);
        check("t4_err_count", n_lenerr - e0, 3);
        check("t4_busy", {31'd0, busy}, 32'd0);

        // Back-to-back len=2 packets; the parity-disabled instance clears bit[0].
        sent0 = n_sent;
        base  = cap_n;
        pw[0] = 28'h3;
        present_desc(4'd3, 12'd2, 8'h01);
        stream_payload(1, 0);
        pw[0] = 28'h5;
        present_desc(4'd3, 12'd2, 8'h02);
        stream_payload(1, 0);
        wait_sent(sent0 + 2);
        check("t5_count", cap_n - base, 4);
        check("t5_h1", cap[base],     32'h20046003);
        check("t5_t1", cap[base + 1], 32'h80000007);
        check("t5_h2", cap[base + 2], 32'h20046005);
        check("t5_t2", cap[base + 3], 32'h8000000B);
        check("t5_np_h1", cap_np[base],     32'h20046002);
        check("t5_np_t1", cap_np[base + 1], 32'h80000006);
        check("t5_np_h2", cap_np[base + 2], 32'h20046004);
        check("t5_np_t2", cap_np[base + 3], 32'h8000000A);
        check("t5_gap0", cap_cyc[base + 1] - cap_cyc[base], 1);
        check("t5_gap1", cap_cyc[base + 2] - cap_cyc[base + 1], 2);
        check("t5_gap2", cap_cyc[base + 3] - cap_cyc[base + 2], 1);

        // Reset asserted in the body of a len=5 packet.
        pw[0] = 28'h10; pw[1] = 28'h20;
        present_desc(4'd3, 12'd5, 8'h03);
        pld_valid = 1'b1;
        pld_data  = pw[0];
        tick();
        pld_data  = pw[1];
        tick();
        check("t6_mid_rts", {31'd0, RTS}, 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_rts", {31'd0, RTS}, 32'd0);
        check("t6_rst_tx", TX, 32'h0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {30'd0, pkt_ready, pld_ready}, 32'd0);
        pld_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        sent0 = n_sent;
        base  = cap_n;
        pw[0] = 28'h3;
        present_desc(4'd3, 12'd2, 8'h01);
        stream_payload(1, 0);
        wait_sent(sent0 + 1);
        check("t6_count", cap_n - base, 2);
        check("t6_hdr", cap[base],     32'h20046003);
        check("t6_tail", cap[base + 1], 32'h80000007);

        // Maximum length packet: 4095 flits without counter wrap.
        for (int k = 0; k < 4094; k++) pw[k] = 28'(k);
        sent0 = n_sent;
        base  = cap_n;
        present_desc(4'd3, 12'd4095, 8'h00);
        check("t7_hdr", TX, 32'h3FFE6001);
        stream_payload(4094, 0);
        wait_sent(sent0 + 1);
        check("t7_count", cap_n - base, 4095);
        check("t7_last_body", cap[base + 4093], 32'h40001FF9);
        check("t7_tail", cap[base + 4094], 32'h80001FFA);
        check("t7_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
